// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB request arbiter.
//   apb_state_e : transfer sequencing states (IDLE, ISSUE, WAIT, RESP)
//   OKAY / SLVERR / DECERR : two-bit response codes returned on bresp/rresp
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } apb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   req[1:0]     : bit 0 = write request, bit 1 = read request
//   accept       : the current grant is taken; updates the history bit
//   grant[1:0]   : one-hot grant (combinational from req and history)
module rr_arb2 (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = read was served last, so write has priority on a tie.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates a write and a read request stream onto a single APB master,
// one transfer outstanding at a time, and returns a response per request.
//   PCLK, PRESET                         : clock, async active-high reset
//   wr_valid/wr_addr/wr_data, wr_ready   : write request and accept pulse
//   rd_valid/rd_addr, rd_ready           : read request and accept pulse
//   req_bit, write_bit, *_pkt            : transfer request to APB master
//   wr_flag, rd_flag, PRDATA, PSLVERR    : completion from APB master
//   bresp_valid/bresp/bresp_ready        : write response handshake
//   rresp_valid/rresp/rdata/rresp_ready  : read response handshake
//
// state | meaning
// IDLE  | waiting for a write or read request
// ISSUE | req_bit high for one cycle, accept pulse visible to requester
// WAIT  | waiting for matching completion flag or timeout
// RESP  | response valid held until matching ready
module apb_req_arbiter
    import apb_bridge_pkg::*;
#(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             wr_valid,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_valid,
    input  logic [ASIZE-1:0] rd_addr,
    output logic             rd_ready,
    output logic             req_bit,
    output logic             write_bit,
    output logic [31:0]      write_addr_pkt,
    output logic [31:0]      write_data_pkt,
    output logic [31:0]      read_addr_pkt,
    input  logic             wr_flag,
    input  logic             rd_flag,
    input  logic [DSIZE-1:0] PRDATA,
    input  logic             PSLVERR,
    output logic             bresp_valid,
    output logic [1:0]       bresp,
    input  logic             bresp_ready,
    output logic             rresp_valid,
    output logic [1:0]       rresp,
    output logic [DSIZE-1:0] rdata,
    input  logic             rresp_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_e    state_q, state_d;
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          accept;
    logic          done;
    logic          timeout;
    logic          resp_taken;
    logic [CW-1:0] cnt_q;

    assign req        = {rd_valid, wr_valid};
    assign accept     = (state_q == IDLE) && (req != 2'b00);
    // write_bit records the current grant, so it also selects the flag/ready.
    assign done       = write_bit ? wr_flag : rd_flag;
    assign timeout    = (cnt_q == CW'(TIMEOUT - 1));
    assign resp_taken = write_bit ? bresp_ready : rresp_ready;

    rr_arb2 u_rr_arb2 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done || timeout) state_d = RESP;
            RESP:    if (resp_taken) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded from registered state only, so all are low while in reset.
    assign req_bit     = (state_q == ISSUE);
    assign bresp_valid = (state_q == RESP) &&  write_bit;
    assign rresp_valid = (state_q == RESP) && !write_bit;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ready       <= 1'b0;
            rd_ready       <= 1'b0;
            write_bit      <= 1'b0;
            write_addr_pkt <= '0;
            write_data_pkt <= '0;
            read_addr_pkt  <= '0;
            cnt_q          <= '0;
            bresp          <= OKAY;
            rresp          <= OKAY;
            rdata          <= '0;
        end else begin
            // Registered accept pulse lands in the ISSUE cycle.
            wr_ready <= accept && grant[0];
            rd_ready <= accept && grant[1];

            if (accept) begin
                write_bit <= grant[0];
                if (grant[0]) begin
                    write_addr_pkt <= 32'(wr_addr);
                    write_data_pkt <= 32'(wr_data);
                end else begin
                    read_addr_pkt <= 32'(rd_addr);
                end
            end

            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && !timeout) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // A flag arriving in the timeout cycle takes precedence.
            if (state_q == WAIT) begin
                if (done) begin
                    if (write_bit) begin
                        bresp <= PSLVERR ? SLVERR : OKAY;
                    end else begin
                        rresp <= PSLVERR ? SLVERR : OKAY;
                        rdata <= PSLVERR ? '0 : PRDATA;
                    end
                end else if (timeout) begin
                    if (write_bit) begin
                        bresp <= DECERR;
                    end else begin
                        rresp <= DECERR;
                        rdata <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        wr_valid = 1'b0, rd_valid = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic        wr_ready, rd_ready, req_bit, write_bit;
    logic [31:0] write_addr_pkt, write_data_pkt, read_addr_pkt;
    logic        wr_flag = 1'b0, rd_flag = 1'b0, PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        bresp_valid, rresp_valid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        bresp_ready = 1'b0, rresp_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];
    bit   side_sb[$];

    apb_req_arbiter #(.DSIZE(32), .ASIZE(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .req_bit(req_bit), .write_bit(write_bit),
        .write_addr_pkt(write_addr_pkt), .write_data_pkt(write_data_pkt),
        .read_addr_pkt(read_addr_pkt),
        .wr_flag(wr_flag), .rd_flag(rd_flag), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .bresp_valid(bresp_valid), .bresp(bresp), .bresp_ready(bresp_ready),
        .rresp_valid(rresp_valid), .rresp(rresp), .rdata(rdata), .rresp_ready(rresp_ready)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        logic [200:0] v;
        v = {wr_ready, rd_ready, req_bit, write_bit, write_addr_pkt, write_data_pkt,
             read_addr_pkt, bresp_valid, rresp_valid, bresp, rresp, rdata};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s outputs not zero: got %h required 0", tag, v);
        end
    endtask

    // flag_dly: cycles after the req_bit cycle at which the matching flag is
    // driven (-1 = never). stall: cycles to hold the response ready low.
    task automatic run_xfer(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                            input int flag_dly, input bit slverr, input logic [31:0] prd,
                            input int stall);
        exp_t e, g;
        int   n, lat;
        bit   got, seen, extra_req, stray;
        bit   flag_hit;
        logic [1:0]  resp0;
        logic [31:0] rdata0;

        flag_hit = (flag_dly >= 1) && (flag_dly <= 16);
        e.is_wr  = is_wr;
        e.resp   = flag_hit ? (slverr ? 2'b10 : 2'b00) : 2'b11;
        e.rdata  = (!is_wr && e.resp == 2'b00) ? prd : 32'h0;
        e.lat    = flag_hit ? flag_dly + 1 : 17;
        sb.push_back(e);

        if (is_wr) begin wr_valid = 1'b1; wr_addr = addr; wr_data = data; end
        else       begin rd_valid = 1'b1; rd_addr = addr; end

        got = 0; n = 0;
        while (!got && n < 20) begin
            tick(); n++;
            if (wr_ready || rd_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_wait no ready within 20 cycles");
            wr_valid = 1'b0; rd_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        checks++;
        if ({wr_ready, rd_ready} !== {is_wr, !is_wr}) begin
            errors++;
            $display("FAIL ready_side got %b required %b", {wr_ready, rd_ready}, {is_wr, !is_wr});
        end
        checks++;
        if (req_bit !== 1'b1 || write_bit !== is_wr) begin
            errors++;
            $display("FAIL issue req_bit=%b write_bit=%b required 1 %b", req_bit, write_bit, is_wr);
        end
        checks++;
        if (is_wr ? (write_addr_pkt !== addr || write_data_pkt !== data) : (read_addr_pkt !== addr)) begin
            errors++;
            $display("FAIL packets got wa=%h wd=%h ra=%h required addr=%h data=%h",
                     write_addr_pkt, write_data_pkt, read_addr_pkt, addr, data);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;

        lat = 0; seen = 0; extra_req = 0; stray = 0;
        PSLVERR = slverr; PRDATA = prd;
        while (!seen && lat < 40) begin
            wr_flag = 1'b0; rd_flag = 1'b0;
            if (flag_dly >= 0 && lat == flag_dly) begin
                if (is_wr) wr_flag = 1'b1; else rd_flag = 1'b1;
            end else if (lat == 1) begin
                // opposite-side flag must be ignored
                if (is_wr) rd_flag = 1'b1; else wr_flag = 1'b1;
            end
            tick(); lat++;
            if (req_bit) extra_req = 1;
            if (wr_ready || rd_ready) stray = 1;
            if (bresp_valid || rresp_valid) seen = 1;
        end
        wr_flag = 1'b0; rd_flag = 1'b0; PSLVERR = 1'b0;

        g = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL resp_wait no response within 40 cycles");
            return;
        end
        checks++;
        if (extra_req || stray) begin
            errors++;
            $display("FAIL wait_phase req_bit=%b ready=%b seen outside ISSUE, required 0 0", extra_req, stray);
        end
        checks++;
        if ({bresp_valid, rresp_valid} !== {g.is_wr, !g.is_wr}) begin
            errors++;
            $display("FAIL resp_side got %b required %b", {bresp_valid, rresp_valid}, {g.is_wr, !g.is_wr});
        end
        checks++;
        if (lat != g.lat) begin
            errors++;
            $display("FAIL latency got %0d required %0d", lat, g.lat);
        end
        resp0  = g.is_wr ? bresp : rresp;
        rdata0 = rdata;
        checks++;
        if (resp0 !== g.resp) begin
            errors++;
            $display("FAIL resp_code got %b required %b", resp0, g.resp);
        end
        if (!g.is_wr) begin
            checks++;
            if (rdata !== g.rdata) begin
                errors++;
                $display("FAIL rdata got %h required %h", rdata, g.rdata);
            end
        end

        for (int s = 0; s < stall; s++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            tick();
            checks++;
            if ((g.is_wr ? bresp_valid : rresp_valid) !== 1'b1 ||
                (g.is_wr ? bresp : rresp) !== resp0 || rdata !== rdata0 ||
                wr_ready !== 1'b0 || rd_ready !== 1'b0 || req_bit !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d valid=%b%b resp=%b rdata=%h ready=%b%b required stable",
                         s, bresp_valid, rresp_valid, g.is_wr ? bresp : rresp, rdata, wr_ready, rd_ready);
            end
        end
        wr_valid = 1'b0; rd_valid = 1'b0;

        bresp_ready = 1'b1; rresp_ready = 1'b1;
        tick();
        bresp_ready = 1'b0; rresp_ready = 1'b0;
        checks++;
        if (bresp_valid !== 1'b0 || rresp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_release valid=%b%b required 00", bresp_valid, rresp_valid);
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        wr_valid = 1'b0; rd_valid = 1'b0;
        PRESET = 1'b0;
        tick();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_single_write();
        run_xfer(1'b1, 32'h10, 32'hA5A5A5A5, 3, 1'b0, 32'h0, 0);
    endtask

    task automatic test_single_read();
        run_xfer(1'b0, 32'h20, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_read_slverr();
        run_xfer(1'b0, 32'h24, 32'h0, 4, 1'b1, 32'h12345678, 0);
    endtask

    task automatic test_write_slverr();
        run_xfer(1'b1, 32'h30, 32'h0BADF00D, 1, 1'b1, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_xfer(1'b1, 32'h40, 32'h11112222, -1, 1'b0, 32'h0, 0);
        run_xfer(1'b1, 32'h44, 32'h33334444, 2, 1'b0, 32'h0, 0);
        run_xfer(1'b0, 32'h48, 32'h0, -1, 1'b0, 32'hCAFEBABE, 0);
    endtask

    task automatic test_flag_at_timeout();
        run_xfer(1'b0, 32'h50, 32'h0, 16, 1'b0, 32'h55AA55AA, 0);
    endtask

    task automatic test_stall();
        run_xfer(1'b0, 32'h60, 32'h0, 3, 1'b0, 32'h0F0F0F0F, 5);
    endtask

    task automatic test_round_robin();
        int n;
        bit got, side;
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        side_sb.push_back(1'b1); side_sb.push_back(1'b0);
        side_sb.push_back(1'b1); side_sb.push_back(1'b0);
        wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 32'h70; wr_data = 32'h77; rd_addr = 32'h74;
        bresp_ready = 1'b1; rresp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 0; n = 0;
            while (!got && n < 20) begin
                tick(); n++;
                if (wr_ready || rd_ready) got = 1;
            end
            side = side_sb.pop_front();
            checks++;
            if (!got || wr_ready !== side || rd_ready !== !side || write_bit !== side) begin
                errors++;
                $display("FAIL rr_grant %0d got wr_ready=%b rd_ready=%b write_bit=%b required write=%b",
                         k, wr_ready, rd_ready, write_bit, side);
            end
            if (k == 3) begin wr_valid = 1'b0; rd_valid = 1'b0; end
            tick();
            if (write_bit) wr_flag = 1'b1; else rd_flag = 1'b1;
            tick();
            wr_flag = 1'b0; rd_flag = 1'b0;
        end
        tick();
        bresp_ready = 1'b0; rresp_ready = 1'b0;
        tick();
        checks++;
        if (req_bit !== 1'b0 || bresp_valid !== 1'b0 || rresp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_settle req_bit=%b valid=%b%b required 0 00", req_bit, bresp_valid, rresp_valid);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        bit got;
        rd_valid = 1'b1; rd_addr = 32'h88;
        got = 0; n = 0;
        while (!got && n < 20) begin
            tick(); n++;
            if (rd_ready) got = 1;
        end
        rd_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midreset_accept no rd_ready within 20 cycles");
        end
        tick(); tick();
        PRESET = 1'b1;
        #1;
        check_all_zero("midreset_async");
        tick();
        PRESET = 1'b0;
        rd_flag = 1'b1; PRDATA = 32'h99999999;
        tick();
        rd_flag = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("midreset_no_resp");
        run_xfer(1'b1, 32'h90, 32'hFEEDFACE, 2, 1'b0, 32'h0, 0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_read_slverr();
        test_write_slverr();
        test_timeout();
        test_flag_at_timeout();
        test_stall();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
